// File: rtl/fc_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// fc_frame_tx_pkg
// Shared definitions for the Fibre Channel frame transmit path:
//   - negative-disparity ordered-set encodings (IDLE, SOFn3, EOFn, EOFa)
//   - K-flag patterns for ordered sets and data words
//   - CRC-32 polynomial / seed and a bit-reverse helper
//   - frame transmitter state enumeration
// No ports (package).
// -----------------------------------------------------------------------------
package fc_frame_tx_pkg;

    // Ordered sets: K28.5 in the top byte followed by three data characters.
    localparam logic [31:0] PRIM_IDLE  = 32'hBC95_B5B5;  // K28.5 D21.4 D21.5 D21.5
    localparam logic [31:0] PRIM_SOFN3 = 32'hBCB5_D6D6;  // K28.5 D21.5 D22.6 D22.6
    localparam logic [31:0] PRIM_EOFN  = 32'hBC95_D5D5;  // K28.5 D21.4 D21.6 D21.6
    localparam logic [31:0] PRIM_EOFA  = 32'hBC95_F5F5;  // K28.5 D21.4 D21.7 D21.7

    localparam logic [3:0] K_PRIM = 4'b1000;
    localparam logic [3:0] K_DATA = 4'b0000;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // The CRC register is kept in reflected (LSB-first) form.
    localparam logic [31:0] CRC_POLY_REFL = bit_rev32(CRC_POLY);

    typedef enum logic [2:0] {
        ST_GAP,
        ST_IDLE,
        ST_SOF,
        ST_DATA,
        ST_CRC,
        ST_EOF,
        ST_DISCARD
    } fc_tx_state_e;

endpackage

// File: rtl/fc_frame_tx_if.sv
// -----------------------------------------------------------------------------
// fc_frame_tx_if
// Avalon-ST style user transmit bus into the frame transmitter.
//   usertx_data          32-bit frame word (header then payload)
//   usertx_valid         word qualifier
//   usertx_startofpacket first word of a frame
//   usertx_endofpacket   last word of a frame
//   usertx_ready         sink ready; a word moves on valid & ready
// Modports: master = frame source, slave = frame transmitter.
// -----------------------------------------------------------------------------
interface fc_frame_tx_if;

    logic [31:0] usertx_data;
    logic        usertx_valid;
    logic        usertx_startofpacket;
    logic        usertx_endofpacket;
    logic        usertx_ready;

    modport master (
        output usertx_data,
        output usertx_valid,
        output usertx_startofpacket,
        output usertx_endofpacket,
        input  usertx_ready
    );

    modport slave (
        input  usertx_data,
        input  usertx_valid,
        input  usertx_startofpacket,
        input  usertx_endofpacket,
        output usertx_ready
    );

endinterface

// File: rtl/fc_crc32.sv
// -----------------------------------------------------------------------------
// fc_crc32
// Combinational one-word CRC-32 update, shared by the TX generator and the
// RX checker.
//   data    32-bit word; bytes consumed [31:24] first, then [23:16], [15:8],
//           [7:0]
//   crc_in  current CRC register (reflected form)
//   crc_out CRC register after folding in all four bytes
// Bits inside each byte are shifted LSB-first against the reflected
// polynomial, the usual FC/Ethernet CRC bit order; the transmitted CRC is
// ~crc_out after the last word (a zero word from the seed gives 0x2144DF1C).
// -----------------------------------------------------------------------------
module fc_crc32
    import fc_frame_tx_pkg::*;
(
    input  logic [31:0] data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int k = 0; k < 4; k++) begin
            c[7:0] = c[7:0] ^ data[31-8*k -: 8];
            for (int j = 0; j < 8; j++) begin
                if (c[0]) begin
                    c = (c >> 1) ^ CRC_POLY_REFL;
                end else begin
                    c = c >> 1;
                end
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/fc_frame_tx.sv
// -----------------------------------------------------------------------------
// fc_frame_tx
// Fibre Channel frame transmitter. Wraps user frames from an Avalon-ST source
// into SOFn3 / data / CRC / EOFn, pads with IDLE words, and aborts frames with
// EOFa on underrun, oversize, link loss or an unexpected start of packet.
//
// Parameters
//   MIN_GAP   minimum IDLE words between an EOF and the next SOF
//   MAX_WORDS maximum header+payload words per frame
// Ports
//   clk             single clock
//   reset_n         asynchronous active-low reset
//   usertx          user transmit bus (slave side)
//   link_active     port state machine is in the active state
//   tx_data         registered transmission word
//   tx_datak        per-byte K flags for tx_data
//   frames_ok       saturating count of frames closed with EOFn
//   frames_aborted  saturating count of frames closed with EOFa
// -----------------------------------------------------------------------------
module fc_frame_tx
    import fc_frame_tx_pkg::*;
#(
    parameter int unsigned MIN_GAP   = 6,
    parameter int unsigned MAX_WORDS = 534
) (
    input  logic               clk,
    input  logic               reset_n,
    fc_frame_tx_if.slave       usertx,
    input  logic               link_active,
    output logic [31:0]        tx_data,
    output logic [3:0]         tx_datak,
    output logic [31:0]        frames_ok,
    output logic [31:0]        frames_aborted
);

    localparam int unsigned GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
    localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);

    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MIN_GAP - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MAX_WORDS);

    fc_tx_state_e      state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [31:0]       crc_q, crc_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic [3:0]        tx_datak_q, tx_datak_d;
    logic [31:0]       frames_ok_q, frames_ok_d;
    logic [31:0]       frames_aborted_q, frames_aborted_d;

    logic [31:0] crc_next;
    logic        ready_c;
    logic        abort_c;
    logic        ok_c;
    logic        sop_valid;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    fc_crc32 u_crc (
        .data    (usertx.usertx_data),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    assign sop_valid = usertx.usertx_valid & usertx.usertx_startofpacket;

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        wcnt_d     = wcnt_q;
        crc_d      = crc_q;
        tx_data_d  = PRIM_IDLE;
        tx_datak_d = K_PRIM;
        ready_c    = 1'b0;
        abort_c    = 1'b0;
        ok_c       = 1'b0;

        case (state_q)
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q >= GAP_LAST) begin
                    gap_cnt_d = '0;
                    // A pending SOP skips the extra IDLE-state word so that
                    // back-to-back frames see exactly MIN_GAP IDLEs.
                    if (sop_valid && link_active) begin
                        state_d = ST_SOF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_IDLE: begin
                // Stray words without SOP are drained; the SOP word is left
                // on the bus for DATA to pick up.
                ready_c = !sop_valid;
                if (sop_valid && link_active) begin
                    state_d = ST_SOF;
                end
            end

            ST_SOF: begin
                if (!link_active) begin
                    abort_c = 1'b1;
                    state_d = ST_DISCARD;
                end else begin
                    tx_data_d = PRIM_SOFN3;
                    crc_d     = CRC_INIT;
                    wcnt_d    = '0;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (!link_active || (wcnt_q == WCNT_MAX) || !usertx.usertx_valid) begin
                    abort_c = 1'b1;
                    state_d = ST_DISCARD;
                end else if (usertx.usertx_startofpacket && (wcnt_q != '0)) begin
                    // A new frame started mid-frame: close this one and let
                    // the SOP word begin the next frame after the gap.
                    abort_c = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    ready_c    = 1'b1;
                    tx_data_d  = usertx.usertx_data;
                    tx_datak_d = K_DATA;
                    crc_d      = crc_next;
                    wcnt_d     = wcnt_q + WCNT_W'(1);
                    if (usertx.usertx_endofpacket) begin
                        state_d = ST_CRC;
                    end
                end
            end

            ST_CRC: begin
                if (!link_active) begin
                    abort_c = 1'b1;
                    state_d = ST_DISCARD;
                end else begin
                    tx_data_d  = ~crc_q;
                    tx_datak_d = K_DATA;
                    state_d    = ST_EOF;
                end
            end

            ST_EOF: begin
                // Link loss here is ignored: the frame is already complete.
                tx_data_d = PRIM_EOFN;
                ok_c      = 1'b1;
                state_d   = ST_GAP;
            end

            ST_DISCARD: begin
                ready_c = !sop_valid;
                if (sop_valid) begin
                    state_d = ST_GAP;
                end else if (usertx.usertx_valid && usertx.usertx_endofpacket) begin
                    state_d = ST_GAP;
                end
            end

            default: begin
                state_d = ST_GAP;
            end
        endcase

        if (abort_c) begin
            tx_data_d  = PRIM_EOFA;
            tx_datak_d = K_PRIM;
        end

        frames_ok_d      = ok_c    ? sat_inc(frames_ok_q)      : frames_ok_q;
        frames_aborted_d = abort_c ? sat_inc(frames_aborted_q) : frames_aborted_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_GAP;
            gap_cnt_q        <= '0;
            wcnt_q           <= '0;
            crc_q            <= CRC_INIT;
            tx_data_q        <= PRIM_IDLE;
            tx_datak_q       <= K_PRIM;
            frames_ok_q      <= '0;
            frames_aborted_q <= '0;
        end else begin
            state_q          <= state_d;
            gap_cnt_q        <= gap_cnt_d;
            wcnt_q           <= wcnt_d;
            crc_q            <= crc_d;
            tx_data_q        <= tx_data_d;
            tx_datak_q       <= tx_datak_d;
            frames_ok_q      <= frames_ok_d;
            frames_aborted_q <= frames_aborted_d;
        end
    end

    assign usertx.usertx_ready = ready_c;
    assign tx_data             = tx_data_q;
    assign tx_datak            = tx_datak_q;
    assign frames_ok           = frames_ok_q;
    assign frames_aborted      = frames_aborted_q;

endmodule

// File: tb/tb_fc_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_fc_frame_tx
// Directed bench for fc_frame_tx: drives frames over the user bus, records
// every transmitted word (K flags + data) at the falling edge and compares
// against hand-written ordered sets and an independent CRC model.
// -----------------------------------------------------------------------------
module tb_fc_frame_tx;

    localparam logic [35:0] W_IDLE = 36'h8_BC95B5B5;
    localparam logic [35:0] W_SOF  = 36'h8_BCB5D6D6;
    localparam logic [35:0] W_EOFN = 36'h8_BC95D5D5;
    localparam logic [35:0] W_EOFA = 36'h8_BC95F5F5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        link_active;
    logic [31:0] tx_data;
    logic [3:0]  tx_datak;
    logic [31:0] frames_ok;
    logic [31:0] frames_aborted;

    always #5 clk = ~clk;

    fc_frame_tx_if utx_if ();

    fc_frame_tx #(.MIN_GAP(6), .MAX_WORDS(534)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .usertx         (utx_if),
        .link_active    (link_active),
        .tx_data        (tx_data),
        .tx_datak       (tx_datak),
        .frames_ok      (frames_ok),
        .frames_aborted (frames_aborted)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [35:0] txq[$];
    bit          cap_en = 1'b0;

    always @(negedge clk) begin
        if (cap_en) txq.push_back({tx_datak, tx_data});
    end

    function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
        return base ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // Forward (MSB-shifting) CRC on bit-reversed input, reversed at the end:
    // equivalent to the reflected FC/Ethernet CRC-32.
    function automatic logic [31:0] crc_model(input logic [31:0] base, input int n);
        logic [31:0] r;
        logic [31:0] w;
        logic [7:0]  b;
        logic        fb;
        logic [31:0] rev;
        r = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            w = word_of(base, i);
            for (int k = 0; k < 4; k++) begin
                b = w[31-8*k -: 8];
                for (int j = 0; j < 8; j++) begin
                    fb = b[j] ^ r[31];
                    r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
                end
            end
        end
        for (int i = 0; i < 32; i++) rev[i] = r[31-i];
        return ~rev;
    endfunction

    function automatic logic [35:0] txq_at(input int i);
        if (i < 0 || i >= txq.size()) return 'x;
        return txq[i];
    endfunction

    function automatic int find_word(input int from, input logic [35:0] w);
        for (int i = (from < 0 ? 0 : from); i < txq.size(); i++) begin
            if (txq[i] === w) return i;
        end
        return -1;
    endfunction

    function automatic int count_non_idle(input int from, input int to);
        int c;
        c = 0;
        for (int i = (from < 0 ? 0 : from); i < to && i < txq.size(); i++) begin
            if (txq[i] !== W_IDLE) c++;
        end
        return c;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int s, input logic [31:0] base, input int n);
        chk({tag, "_sof"}, txq_at(s), W_SOF);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_w%0d", tag, i), txq_at(s + 1 + i), {4'h0, word_of(base, i)});
        end
        chk({tag, "_crc"}, txq_at(s + 1 + n), {4'h0, crc_model(base, n)});
        chk({tag, "_eof"}, txq_at(s + 2 + n), W_EOFN);
    endtask

    // Presents words first..last of an n_total-word frame, each held until
    // the DUT accepts it (ready sampled at the falling edge before the
    // accepting rising edge).
    task automatic drive_words(input logic [31:0] base, input int first, input int last,
                               input int n_total);
        bit acc;
        int budget;
        for (int i = first; i <= last; i++) begin
            utx_if.usertx_valid         = 1'b1;
            utx_if.usertx_data          = word_of(base, i);
            utx_if.usertx_startofpacket = (i == 0);
            utx_if.usertx_endofpacket   = (i == n_total - 1);
            acc    = 1'b0;
            budget = 0;
            while (!acc && budget < 2000) begin
                @(negedge clk);
                acc = utx_if.usertx_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            n_checks++;
            assert (acc === 1'b1) n_pass++;
            else begin
                n_fail++;
                $error("FAIL handshake_w%0d: accepted %0d required 1", i, acc);
            end
        end
    endtask

    task automatic src_idle();
        utx_if.usertx_valid         = 1'b0;
        utx_if.usertx_startofpacket = 1'b0;
        utx_if.usertx_endofpacket   = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s;
        int s2;
        int e;
        int errs;

        // ---------------- reset state ----------------
        reset_n            = 1'b0;
        link_active        = 1'b1;
        utx_if.usertx_data = 32'h0;
        src_idle();
        #12;
        chk("rst_tx_data", {4'h0, tx_data}, {4'h0, 32'hBC95B5B5});
        chk("rst_tx_datak", {32'h0, tx_datak}, {32'h0, 4'b1000});
        chk("rst_ready", {35'h0, utx_if.usertx_ready}, 36'h0);
        chk("rst_frames_ok", {4'h0, frames_ok}, 36'h0);
        chk("rst_frames_aborted", {4'h0, frames_aborted}, 36'h0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        txq.delete();
        cap_en = 1'b1;
        step(1);
        chk("gap_ready", {35'h0, utx_if.usertx_ready}, 36'h0);
        step(19);
        chk("idle_ready", {35'h0, utx_if.usertx_ready}, 36'h1);
        chk("post_reset_idle", 36'(count_non_idle(0, txq.size())), 36'h0);

        // ---------------- single zero word frame ----------------
        txq.delete();
        drive_words(32'h0, 0, 0, 1);
        src_idle();
        step(15);
        s = find_word(0, W_SOF);
        chk("t2_pre_idle", 36'(count_non_idle(0, s)), 36'h0);
        chk("t2_sof", txq_at(s), W_SOF);
        chk("t2_word", txq_at(s + 1), 36'h0_00000000);
        chk("t2_crc", txq_at(s + 2), 36'h0_2144DF1C);
        chk("t2_eof", txq_at(s + 3), W_EOFN);
        chk("t2_frames_ok", {4'h0, frames_ok}, 36'd1);
        chk("t2_frames_aborted", {4'h0, frames_aborted}, 36'd0);

        // ---------------- back-to-back 10-word frames ----------------
        txq.delete();
        drive_words(32'h1122_3344, 0, 9, 10);
        drive_words(32'hA5A5_0F0F, 0, 9, 10);
        src_idle();
        step(30);
        s = find_word(0, W_SOF);
        chk_frame("t3a", s, 32'h1122_3344, 10);
        e  = s + 12;
        s2 = find_word(e + 1, W_SOF);
        chk("t3_gap_len", 36'(s2 - e - 1), 36'd6);
        chk("t3_gap_idle", 36'(count_non_idle(e + 1, s2)), 36'h0);
        chk_frame("t3b", s2, 32'hA5A5_0F0F, 10);
        chk("t3_frames_ok", {4'h0, frames_ok}, 36'd3);

        // ---------------- underrun after word 3 of 8 ----------------
        txq.delete();
        drive_words(32'hDEAD_BEEF, 0, 2, 8);
        utx_if.usertx_valid = 1'b0;
        step(1);
        drive_words(32'hDEAD_BEEF, 3, 7, 8);
        src_idle();
        step(15);
        s = find_word(0, W_SOF);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_w%0d", i), txq_at(s + 1 + i), {4'h0, word_of(32'hDEAD_BEEF, i)});
        end
        chk("t4_eofa", txq_at(s + 4), W_EOFA);
        chk("t4_no_restart", 36'(find_word(s + 1, W_SOF)), 36'(-1));
        chk("t4_frames_aborted", {4'h0, frames_aborted}, 36'd1);
        chk("t4_frames_ok", {4'h0, frames_ok}, 36'd3);

        // ---------------- oversize frame, then a good frame ----------------
        txq.delete();
        drive_words(32'h0BAD_F00D, 0, 534, 535);
        drive_words(32'h1357_9BDF, 0, 1, 2);
        src_idle();
        step(20);
        s    = find_word(0, W_SOF);
        errs = 0;
        for (int i = 0; i < 534; i++) begin
            if (txq_at(s + 1 + i) !== {4'h0, word_of(32'h0BAD_F00D, i)}) errs++;
        end
        chk("t5_payload_errs", 36'(errs), 36'h0);
        chk("t5_eofa", txq_at(s + 535), W_EOFA);
        s2 = find_word(s + 536, W_SOF);
        chk("t5_gap_idle", 36'(count_non_idle(s + 536, s2)), 36'h0);
        chk_frame("t5c", s2, 32'h1357_9BDF, 2);
        chk("t5_frames_aborted", {4'h0, frames_aborted}, 36'd2);
        chk("t5_frames_ok", {4'h0, frames_ok}, 36'd4);

        // ---------------- SOP arriving mid-frame ----------------
        txq.delete();
        drive_words(32'h0102_0304, 0, 2, 5);
        drive_words(32'hCAFE_BABE, 0, 1, 2);
        src_idle();
        step(20);
        s = find_word(0, W_SOF);
        chk("t6_w2", txq_at(s + 3), {4'h0, word_of(32'h0102_0304, 2)});
        chk("t6_eofa", txq_at(s + 4), W_EOFA);
        s2 = find_word(s + 5, W_SOF);
        chk("t6_gap_len", 36'(s2 - (s + 4) - 1), 36'd6);
        chk_frame("t6e", s2, 32'hCAFE_BABE, 2);
        chk("t6_frames_aborted", {4'h0, frames_aborted}, 36'd3);
        chk("t6_frames_ok", {4'h0, frames_ok}, 36'd5);

        // ---------------- link loss during DATA ----------------
        txq.delete();
        drive_words(32'h55AA_33CC, 0, 1, 4);
        link_active                 = 1'b0;
        utx_if.usertx_data          = word_of(32'h55AA_33CC, 2);
        utx_if.usertx_startofpacket = 1'b0;
        utx_if.usertx_endofpacket   = 1'b0;
        step(1);
        drive_words(32'h55AA_33CC, 2, 3, 4);
        src_idle();
        link_active = 1'b1;
        step(15);
        s = find_word(0, W_SOF);
        chk("t7_w1", txq_at(s + 2), {4'h0, word_of(32'h55AA_33CC, 1)});
        chk("t7_eofa", txq_at(s + 3), W_EOFA);
        chk("t7_frames_aborted", {4'h0, frames_aborted}, 36'd4);
        chk("t7_frames_ok", {4'h0, frames_ok}, 36'd5);

        // ---------------- reset pulsed mid-frame ----------------
        drive_words(32'h7654_3210, 0, 2, 6);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst2_tx_data", {4'h0, tx_data}, {4'h0, 32'hBC95B5B5});
        chk("rst2_tx_datak", {32'h0, tx_datak}, {32'h0, 4'b1000});
        chk("rst2_ready", {35'h0, utx_if.usertx_ready}, 36'h0);
        chk("rst2_frames_ok", {4'h0, frames_ok}, 36'h0);
        chk("rst2_frames_aborted", {4'h0, frames_aborted}, 36'h0);
        utx_if.usertx_valid         = 1'b1;
        utx_if.usertx_data          = word_of(32'h0F1E_2D3C, 0);
        utx_if.usertx_startofpacket = 1'b1;
        utx_if.usertx_endofpacket   = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        txq.delete();
        drive_words(32'h0F1E_2D3C, 0, 0, 1);
        src_idle();
        step(12);
        s = find_word(0, W_SOF);
        chk("t8_idle_before_sof", 36'(s), 36'd6);
        chk("t8_pre_idle", 36'(count_non_idle(0, s)), 36'h0);
        chk_frame("t8", s, 32'h0F1E_2D3C, 1);
        chk("t8_frames_ok", {4'h0, frames_ok}, 36'd1);
        chk("t8_frames_aborted", {4'h0, frames_aborted}, 36'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
